bcd_lap_counter: RTL and testbench

BCD_LAP_COUNTER -- requirements
Module: bcd_lap_counter

---
 rtl/bcd_lap_counter.sv | 127 ++++++++++++
 tb/tb_bcd_lap_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_lap_counter.sv
// Multi-digit BCD up/down counter with saturation and a circular lap-record buffer.
// Toggle controls are pulses; every output comes from registered state.
module bcd_lap_counter #(
   parameter int NDIG  = 2,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       tick,
   input  logic                       en_p,
   input  logic                       dir_p,
   input  logic                       rec_p,
   input  logic                       recall_p,
   input  logic                       clr_p,
   output logic [4*NDIG-1:0]          count,
   output logic [4*NDIG-1:0]          lap,
   output logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic [$clog2(DEPTH):0]     lap_cnt,
   output logic                       enabled,
   output logic                       up,
   output logic                       max,
   output logic                       min,
   output logic                       full
);
   localparam int AW = $clog2(DEPTH);
   localparam int W  = 4 * NDIG;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [W-1:0]  cnt_q, cnt_d, cnt_inc, cnt_dec;
   logic [W-1:0]  slots [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   lcnt_q, lcnt_d;
   logic          en_q, up_q, we;
   logic          all9, all0, carry, borrow;

   // Ripple BCD increment/decrement; carry/borrow stops at the first digit not at its limit.
   always_comb begin
      cnt_inc = cnt_q;
      cnt_dec = cnt_q;
      all9    = 1'b1;
      all0    = 1'b1;
      carry   = 1'b1;
      borrow  = 1'b1;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (cnt_q[4*i +: 4] != 4'd9) all9 = 1'b0;
         if (cnt_q[4*i +: 4] != 4'd0) all0 = 1'b0;
         if (carry) begin
            if (cnt_q[4*i +: 4] == 4'd9) begin
               cnt_inc[4*i +: 4] = 4'd0;
            end else begin
               cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (cnt_q[4*i +: 4] == 4'd0) begin
               cnt_dec[4*i +: 4] = 4'd9;
            end else begin
               cnt_dec[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      lcnt_d = lcnt_q;
      we     = 1'b0;
      if (clr_p) begin
         cnt_d = '0;
      end else if (tick && en_q) begin
         if (up_q) begin
            if (!all9) cnt_d = cnt_inc;
         end else begin
            if (!all0) cnt_d = cnt_dec;
         end
      end
      if (rec_p) begin
         we   = 1'b1;
         wr_d = wr_q + PTR_ONE;
         rd_d = wr_q;
         if (lcnt_q != FULL_CNT) lcnt_d = lcnt_q + CNT_ONE;
      end else if (recall_p && (lcnt_q != '0)) begin
         // Before the buffer fills, valid slots are 0..lap_cnt-1, so wrap early.
         if ((lcnt_q != FULL_CNT) && ({1'b0, rd_q} == (lcnt_q - CNT_ONE)))
            rd_d = '0;
         else
            rd_d = rd_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         lcnt_q <= '0;
         en_q   <= 1'b0;
         up_q   <= 1'b1;
         for (int unsigned i = 0; i < DEPTH; i++) slots[i] <= '0;
      end else begin
         cnt_q  <= cnt_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         lcnt_q <= lcnt_d;
         en_q   <= en_q ^ en_p;
         up_q   <= up_q ^ dir_p;
         if (we) slots[wr_q] <= cnt_q;
      end
   end

   assign count   = cnt_q;
   assign lap     = (lcnt_q == '0) ? '0 : slots[rd_q];
   assign rd_idx  = rd_q;
   assign lap_cnt = lcnt_q;
   assign enabled = en_q;
   assign up      = up_q;
   assign max     = all9 & up_q;
   assign min     = all0 & ~up_q;
   assign full    = (lcnt_q == FULL_CNT);

endmodule

// File: tb/tb_bcd_lap_counter.sv
// Directed bench for bcd_lap_counter (NDIG=2, DEPTH=4): counting, saturation,
// lap buffer behaviour and asynchronous reset.
module tb_bcd_lap_counter;
   logic       clk = 1'b0;
   logic       reset, tick, en_p, dir_p, rec_p, recall_p, clr_p;
   logic [7:0] count, lap;
   logic [1:0] rd_idx;
   logic [2:0] lap_cnt;
   logic       enabled, up, max, min, full;

   int checks   = 0;
   int failures = 0;

   bcd_lap_counter #(.NDIG(2), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .tick(tick), .en_p(en_p), .dir_p(dir_p),
      .rec_p(rec_p), .recall_p(recall_p), .clr_p(clr_p),
      .count(count), .lap(lap), .rd_idx(rd_idx), .lap_cnt(lap_cnt),
      .enabled(enabled), .up(up), .max(max), .min(min), .full(full)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] bcd(input int n);
      return 32'((n / 10) * 16 + (n % 10));
   endfunction

   // One clock with the given pulses held across the edge; returns #1 after the edge.
   task automatic cyc(input logic t, input logic e, input logic d,
                      input logic r, input logic rc, input logic c);
      tick = t; en_p = e; dir_p = d; rec_p = r; recall_p = rc; clr_p = c;
      @(posedge clk);
      #1;
      tick = 0; en_p = 0; dir_p = 0; rec_p = 0; recall_p = 0; clr_p = 0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 0, 0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count"},   32'(count),   0);
      chk({tag, "_lap"},     32'(lap),     0);
      chk({tag, "_rd_idx"},  32'(rd_idx),  0);
      chk({tag, "_lap_cnt"}, 32'(lap_cnt), 0);
      chk({tag, "_enabled"}, 32'(enabled), 0);
      chk({tag, "_up"},      32'(up),      1);
      chk({tag, "_max"},     32'(max),     0);
      chk({tag, "_min"},     32'(min),     0);
      chk({tag, "_full"},    32'(full),    0);
   endtask

   initial begin
      reset = 1; tick = 0; en_p = 0; dir_p = 0; rec_p = 0; recall_p = 0; clr_p = 0;
      @(posedge clk); #1;
      // Pulses during reset are discarded
      en_p = 1; dir_p = 1; rec_p = 1; tick = 1;
      @(posedge clk); #1;
      en_p = 0; dir_p = 0; rec_p = 0; tick = 0;
      chk_reset_state("rst");
      #2 reset = 0;
      @(posedge clk); #1;
      chk("post_rst_enabled", 32'(enabled), 0);
      ticks(1);
      chk("tick_disabled", 32'(count), 0);

      // Up-count 00..99 then saturate
      cyc(0, 1, 0, 0, 0, 0);
      chk("en_toggle", 32'(enabled), 1);
      for (int n = 1; n <= 99; n++) begin
         ticks(1);
         chk("up_count", 32'(count), bcd(n));
      end
      chk("max_at_99", 32'(max), 1);
      ticks(2);
      chk("sat_99", 32'(count), 32'h99);
      chk("max_hold", 32'(max), 1);

      // clr overrides tick
      cyc(1, 0, 0, 0, 0, 1);
      chk("clr_tick", 32'(count), 0);
      chk("clr_max", 32'(max), 0);
      chk("clr_enabled", 32'(enabled), 1);

      // Down-count 10..00 then saturate
      ticks(10);
      chk("cnt_10", 32'(count), 32'h10);
      cyc(0, 0, 1, 0, 0, 0);
      chk("dir_up", 32'(up), 0);
      chk("dir_count_hold", 32'(count), 32'h10);
      for (int n = 9; n >= 0; n--) begin
         ticks(1);
         chk("down_count", 32'(count), bcd(n));
      end
      chk("min_at_00", 32'(min), 1);
      ticks(1);
      chk("sat_00", 32'(count), 0);
      chk("min_hold", 32'(min), 1);
      // dir_p with tick: old (down) direction applies, stays 00
      cyc(1, 0, 1, 0, 0, 0);
      chk("dir_tick_count", 32'(count), 0);
      chk("dir_tick_up", 32'(up), 1);
      chk("dir_tick_min", 32'(min), 0);

      // Lap records at 05,12,20,33,41
      ticks(5);  cyc(0, 0, 0, 1, 0, 0);
      chk("rec1_lap", 32'(lap), 32'h05);
      chk("rec1_cnt", 32'(lap_cnt), 1);
      ticks(7);  cyc(0, 0, 0, 1, 0, 0);
      ticks(8);  cyc(0, 0, 0, 1, 0, 0);
      ticks(13); cyc(0, 0, 0, 1, 0, 0);
      chk("rec4_lap", 32'(lap), 32'h33);
      chk("rec4_rd", 32'(rd_idx), 3);
      chk("rec4_full", 32'(full), 1);
      ticks(8);  cyc(0, 0, 0, 1, 0, 0);
      chk("rec5_cnt", 32'(lap_cnt), 4);
      chk("rec5_full", 32'(full), 1);
      chk("rec5_rd", 32'(rd_idx), 0);
      chk("rec5_lap", 32'(lap), 32'h41);
      cyc(0, 0, 0, 0, 1, 0);
      chk("recall_a", 32'(lap), 32'h12);
      cyc(0, 0, 0, 0, 1, 0);
      chk("recall_b", 32'(lap), 32'h20);
      cyc(0, 0, 0, 0, 1, 0);
      chk("recall_c", 32'(lap), 32'h33);
      cyc(0, 0, 0, 0, 1, 0);
      chk("recall_d", 32'(lap), 32'h41);
      chk("recall_d_rd", 32'(rd_idx), 0);

      // rec with tick at 07 stores pre-tick value
      cyc(0, 0, 0, 0, 0, 1);
      ticks(7);
      cyc(1, 0, 0, 1, 0, 0);
      chk("rectick_lap", 32'(lap), 32'h07);
      chk("rectick_rd", 32'(rd_idx), 1);
      chk("rectick_count", 32'(count), 32'h08);
      chk("rectick_lapcnt", 32'(lap_cnt), 4);
      // rec wins over recall
      cyc(0, 0, 0, 1, 1, 0);
      chk("prio_rd", 32'(rd_idx), 2);
      chk("prio_lap", 32'(lap), 32'h08);

      // Fresh run: recall on empty buffer, wrap before full, async reset at 57
      reset = 1; #2 reset = 0;
      @(posedge clk); #1;
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("empty_recall_rd", 32'(rd_idx), 0);
      chk("empty_recall_lap", 32'(lap), 0);
      ticks(10); cyc(0, 0, 0, 1, 0, 0);
      ticks(10); cyc(0, 0, 0, 1, 0, 0);
      ticks(10); cyc(0, 0, 0, 1, 0, 0);
      chk("three_cnt", 32'(lap_cnt), 3);
      chk("three_rd", 32'(rd_idx), 2);
      cyc(0, 0, 0, 0, 1, 0);
      chk("wrap_rd", 32'(rd_idx), 0);
      chk("wrap_lap", 32'(lap), 32'h10);
      cyc(0, 0, 0, 0, 1, 0);
      chk("wrap_next_lap", 32'(lap), 32'h20);
      ticks(26);
      chk("cnt_56", 32'(count), 32'h56);
      cyc(1, 1, 0, 0, 0, 0);
      chk("en_tick_count", 32'(count), 32'h57);
      chk("en_tick_enabled", 32'(enabled), 0);
      ticks(1);
      chk("disabled_hold", 32'(count), 32'h57);
      #2 reset = 1;
      #1;
      chk_reset_state("async");
      #1 reset = 0;
      @(posedge clk); #1;
      ticks(1);
      chk("after_rst_tick", 32'(count), 0);
      cyc(0, 1, 0, 0, 0, 0);
      ticks(1);
      chk("after_rst_en", 32'(count), 32'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
